safety_soc_ctrl_regs: RTL and testbench

- Register-bus responder for the SocCtrl window (offset 0x0000, 4 KiB) of the safety island peripheral interconnect.
- Holds the boot address, fetch enable, core status/end-of-computation word and the sampled boot mode.
- Contains a boot sequencer. In Preloaded mode it raises fetch enable by itself after a programmable delay. In Jtag mode it waits for a debugger or host write.
- Its outputs drive the core complex's fetch_enable and boot_addr inputs.

---
 rtl/safety_soc_ctrl_regs.sv | 222 ++++++++++++++++++++++
 tb/tb_safety_soc_ctrl_regs.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/safety_soc_ctrl_regs.sv
// -----------------------------------------------------------------------------
// safety_soc_ctrl_regs
//
// SocCtrl register window of the safety island. Holds the boot address, the
// fetch enable, the core status / end-of-computation word and the boot mode
// sampled after reset. A small boot sequencer raises fetch enable by itself in
// Preloaded mode after BootDelay cycles. In Jtag mode it waits for a bus write.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   bootmode_i          boot mode pins (00 Jtag, 01 Preloaded, 1x as Jtag)
//   req_valid_i/ready_o request handshake (one outstanding request)
//   req_addr_i          byte address inside the 4 KiB window
//   req_write_i         1 = write, 0 = read
//   req_wdata_i/wstrb_i write data and byte strobes
//   rsp_valid_o         one-cycle response pulse, one cycle after accept
//   rsp_rdata_o         read data (0 for writes and errors)
//   rsp_error_o         error flag, qualified by rsp_valid_o
//   fetch_enable_o      FETCHEN[0]
//   boot_addr_o         BOOTADDR
//   eoc_o               CORESTATUS[31]
//   core_status_o       CORESTATUS
// -----------------------------------------------------------------------------
module safety_soc_ctrl_regs #(
    parameter int unsigned AddrWidth       = 12,
    parameter logic [31:0] BootAddrDefault = 32'h0000_1080,
    parameter int unsigned BootDelay       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           bootmode_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_wstrb_i,
    output logic                 rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic                 fetch_enable_o,
    output logic [31:0]          boot_addr_o,
    output logic                 eoc_o,
    output logic [31:0]          core_status_o
);

    localparam int unsigned CntW = (BootDelay > 1) ? $clog2(BootDelay) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(BootDelay - 1);

    localparam logic [AddrWidth-3:0] IdxBootAddr   = (AddrWidth-2)'(0);
    localparam logic [AddrWidth-3:0] IdxFetchEn    = (AddrWidth-2)'(1);
    localparam logic [AddrWidth-3:0] IdxCoreStatus = (AddrWidth-2)'(2);
    localparam logic [AddrWidth-3:0] IdxBootMode   = (AddrWidth-2)'(3);
    localparam logic [AddrWidth-3:0] IdxBootState  = (AddrWidth-2)'(4);

    typedef enum logic [2:0] {
        ST_SAMPLE = 3'd0,
        ST_WAIT   = 3'd1,
        ST_COUNT  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     bootaddr_q, bootaddr_d;
    logic            fetchen_q, fetchen_d;
    logic [31:0]     corestatus_q, corestatus_d;
    logic [1:0]      bootmode_q, bootmode_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_error_q, rsp_error_d;

    logic                 accept;
    logic [AddrWidth-3:0] word_idx;
    logic                 addr_hit;
    logic                 addr_ro;
    logic [31:0]          rdata_mux;
    logic                 wr_ok;
    logic                 auto_set;

    // Byte offset within a word does not select anything.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr_i[1:0];

    assign accept   = req_valid_i & req_ready_o;
    assign word_idx = req_addr_i[AddrWidth-1:2];

    // Address decode and read mux, using register values before the edge.
    always_comb begin
        rdata_mux = '0;
        addr_hit  = 1'b1;
        addr_ro   = 1'b0;
        case (word_idx)
            IdxBootAddr:   rdata_mux = bootaddr_q;
            IdxFetchEn:    rdata_mux = {31'b0, fetchen_q};
            IdxCoreStatus: rdata_mux = corestatus_q;
            IdxBootMode: begin
                rdata_mux = {30'b0, bootmode_q};
                addr_ro   = 1'b1;
            end
            IdxBootState: begin
                rdata_mux = {29'b0, state_q};
                addr_ro   = 1'b1;
            end
            default:       addr_hit  = 1'b0;
        endcase
    end

    assign wr_ok = accept & req_write_i & addr_hit & ~addr_ro;

    // Boot sequencer next state. The auto-set pulse is consumed even if a
    // simultaneous bus write overrides the FETCHEN value.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bootmode_d = bootmode_q;
        auto_set   = 1'b0;
        case (state_q)
            ST_SAMPLE: begin
                bootmode_d = bootmode_i;
                if (bootmode_i == 2'b01) begin
                    state_d = ST_COUNT;
                    cnt_d   = CntLoad;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fetchen_q) state_d = ST_RUN;
            end
            ST_COUNT: begin
                if (fetchen_q) begin
                    state_d = ST_RUN;
                end else if (cnt_q == '0) begin
                    auto_set = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (corestatus_q[31]) state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_SAMPLE;
        endcase
    end

    // Register file and response next values.
    always_comb begin
        bootaddr_d   = bootaddr_q;
        corestatus_d = corestatus_q;
        fetchen_d    = fetchen_q | auto_set;
        if (wr_ok) begin
            case (word_idx)
                IdxBootAddr:   bootaddr_d   = apply_strb(bootaddr_q, req_wdata_i, req_wstrb_i);
                IdxCoreStatus: corestatus_d = apply_strb(corestatus_q, req_wdata_i, req_wstrb_i);
                IdxFetchEn: begin
                    // Bus write has priority over the sequencer auto-set.
                    if (req_wstrb_i[0]) fetchen_d = req_wdata_i[0];
                end
                default: ;
            endcase
        end

        rsp_valid_d = accept;
        rsp_rdata_d = (accept & ~req_write_i & addr_hit) ? rdata_mux : 32'b0;
        rsp_error_d = accept & (~addr_hit | (req_write_i & addr_ro));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_SAMPLE;
            cnt_q        <= '0;
            bootaddr_q   <= BootAddrDefault;
            fetchen_q    <= 1'b0;
            corestatus_q <= '0;
            bootmode_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bootaddr_q   <= bootaddr_d;
            fetchen_q    <= fetchen_d;
            corestatus_q <= corestatus_d;
            bootmode_q   <= bootmode_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    // Outputs are direct views of the registers; one request in flight only.
    always_comb begin
        req_ready_o    = ~rsp_valid_q;
        rsp_valid_o    = rsp_valid_q;
        rsp_rdata_o    = rsp_rdata_q;
        rsp_error_o    = rsp_error_q;
        fetch_enable_o = fetchen_q;
        boot_addr_o    = bootaddr_q;
        eoc_o          = corestatus_q[31];
        core_status_o  = corestatus_q;
    end

endmodule

// File: tb/tb_safety_soc_ctrl_regs.sv
// -----------------------------------------------------------------------------
// Testbench for safety_soc_ctrl_regs. Two instances (BootDelay 16 and 4) share
// all inputs and are each compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_safety_soc_ctrl_regs;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  bootmode;
    logic        req_valid;
    logic [11:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic [1:0]        req_ready, rsp_valid, rsp_error, fetch_en, eoc;
    logic [1:0][31:0]  rsp_rdata, boot_addr, core_status;

    int n_vec = 0;
    int n_err = 0;

    safety_soc_ctrl_regs #(.AddrWidth(12), .BootAddrDefault(32'h0000_1080), .BootDelay(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .bootmode_i(bootmode),
        .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_error_o(rsp_error[0]),
        .fetch_enable_o(fetch_en[0]), .boot_addr_o(boot_addr[0]), .eoc_o(eoc[0]),
        .core_status_o(core_status[0])
    );

    safety_soc_ctrl_regs #(.AddrWidth(12), .BootAddrDefault(32'h0000_1080), .BootDelay(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .bootmode_i(bootmode),
        .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_error_o(rsp_error[1]),
        .fetch_enable_o(fetch_en[1]), .boot_addr_o(boot_addr[1]), .eoc_o(eoc[1]),
        .core_status_o(core_status[1])
    );

    // ---------------- behavioural reference model ----------------
    // Boot phases: 0 sample, 1 wait-for-host, 2 counting, 3 running, 4 done.
    logic [31:0] m_bootaddr [2];
    logic [31:0] m_status   [2];
    logic        m_fetch    [2];
    logic [1:0]  m_mode     [2];
    int          m_phase    [2];
    int          m_left     [2];
    logic        m_rv       [2];
    logic [31:0] m_rdata    [2];
    logic        m_err      [2];

    function automatic int dly(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    function automatic logic [31:0] wmerge(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int          idx;
        bit          acc, known, ro, auto;
        logic        n_fetch;
        if (!rst_n) begin
            m_bootaddr[k] = 32'h0000_1080; m_status[k] = '0; m_fetch[k] = 1'b0;
            m_mode[k] = 2'b00; m_phase[k] = 0; m_left[k] = 0;
            m_rv[k] = 1'b0; m_rdata[k] = '0; m_err[k] = 1'b0;
            return;
        end
        acc   = req_valid && !m_rv[k];
        idx   = int'(req_addr[11:2]);
        known = (idx <= 4);
        ro    = (idx == 3) || (idx == 4);

        // Response reflects the register contents before this edge.
        m_rdata[k] = '0;
        m_err[k]   = 1'b0;
        if (acc) begin
            if (!known || (req_write && ro)) m_err[k] = 1'b1;
            else if (!req_write) begin
                case (idx)
                    0: m_rdata[k] = m_bootaddr[k];
                    1: m_rdata[k] = {31'b0, m_fetch[k]};
                    2: m_rdata[k] = m_status[k];
                    3: m_rdata[k] = {30'b0, m_mode[k]};
                    default: m_rdata[k] = 32'(m_phase[k]);
                endcase
            end
        end

        // Sequencer, decided on pre-edge register values.
        auto = 1'b0;
        case (m_phase[k])
            0: begin
                m_mode[k] = bootmode;
                if (bootmode == 2'b01) begin m_phase[k] = 2; m_left[k] = dly(k) - 1; end
                else m_phase[k] = 1;
            end
            1: if (m_fetch[k]) m_phase[k] = 3;
            2: begin
                if (m_fetch[k]) m_phase[k] = 3;
                else if (m_left[k] == 0) begin auto = 1'b1; m_phase[k] = 3; end
                else m_left[k] = m_left[k] - 1;
            end
            3: if (m_status[k][31]) m_phase[k] = 4;
            default: ;
        endcase

        n_fetch = m_fetch[k] | auto;
        if (acc && req_write && known && !ro) begin
            case (idx)
                0: m_bootaddr[k] = wmerge(m_bootaddr[k], req_wdata, req_wstrb);
                1: if (req_wstrb[0]) n_fetch = req_wdata[0];
                default: m_status[k] = wmerge(m_status[k], req_wdata, req_wstrb);
            endcase
        end
        m_fetch[k] = n_fetch;
        m_rv[k]    = acc;
    endtask

    task automatic compare(input int k);
        check($sformatf("d%0d.ready", k), 32'(req_ready[k]), 32'(!m_rv[k]));
        check($sformatf("d%0d.rsp_valid", k), 32'(rsp_valid[k]), 32'(m_rv[k]));
        if (m_rv[k]) begin
            check($sformatf("d%0d.rdata", k), rsp_rdata[k], m_rdata[k]);
            check($sformatf("d%0d.error", k), 32'(rsp_error[k]), 32'(m_err[k]));
        end
        check($sformatf("d%0d.fetch_en", k), 32'(fetch_en[k]), 32'(m_fetch[k]));
        check($sformatf("d%0d.boot_addr", k), boot_addr[k], m_bootaddr[k]);
        check($sformatf("d%0d.eoc", k), 32'(eoc[k]), 32'(m_status[k][31]));
        check($sformatf("d%0d.core_status", k), core_status[k], m_status[k]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            compare(k);
        end
    endtask

    // One bus access; the response is on the outputs when this returns.
    task automatic bus(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        if (m_rv[0]) tick();
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] mode);
        bootmode = mode;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; bootmode = 2'b01; req_valid = 1'b0; req_addr = '0;
        req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
        for (int k = 0; k < 2; k++) begin
            m_bootaddr[k] = '0; m_status[k] = '0; m_fetch[k] = 1'b0; m_mode[k] = '0;
            m_phase[k] = 0; m_left[k] = 0; m_rv[k] = 1'b0; m_rdata[k] = '0; m_err[k] = 1'b0;
        end

        // Reset state and Preloaded auto boot.
        do_reset(2'b01);
        check("rst.ready", 32'(req_ready[0]), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst.boot_addr", boot_addr[0], 32'h0000_1080);
        tick();                                   // SAMPLE cycle
        bus(1'b0, 12'h010, '0, 4'h0);             // second cycle after release
        check("pre.bootstate_count", rsp_rdata[0], 32'd2);
        repeat (14) tick();                       // 16 cycles after release
        check("pre.fetch_before", 32'(fetch_en[0]), 32'd0);
        tick();                                   // 17th cycle
        check("pre.fetch_rise", 32'(fetch_en[0]), 32'd1);
        check("pre4.fetch", 32'(fetch_en[1]), 32'd1);
        bus(1'b0, 12'h010, '0, 4'h0);
        check("pre.bootstate_run", rsp_rdata[0], 32'd3);

        // Jtag: waits for host.
        do_reset(2'b00);
        repeat (100) tick();
        check("jtag.idle_fetch", 32'(fetch_en[0]), 32'd0);
        bus(1'b1, 12'h000, 32'h1C00_0080, 4'hF);
        check("jtag.boot_addr", boot_addr[0], 32'h1C00_0080);
        bus(1'b1, 12'h004, 32'h0000_0001, 4'hF);
        check("jtag.fetch", 32'(fetch_en[0]), 32'd1);
        bus(1'b0, 12'h010, '0, 4'h0);
        check("jtag.bootstate", rsp_rdata[0], 32'd3);

        // End of computation.
        bus(1'b1, 12'h008, 32'h8000_0000, 4'hF);
        check("eoc.eoc", 32'(eoc[0]), 32'd1);
        check("eoc.status", core_status[0], 32'h8000_0000);
        bus(1'b0, 12'h010, '0, 4'h0);
        check("eoc.bootstate", rsp_rdata[0], 32'd4);
        bus(1'b0, 12'h008, '0, 4'h0);
        check("eoc.read", rsp_rdata[0], 32'h8000_0000);
        check("eoc.read_err", 32'(rsp_error[0]), 32'd0);

        // Error responses.
        bus(1'b0, 12'h014, '0, 4'h0);
        check("err.rd14", 32'(rsp_error[0]), 32'd1);
        check("err.rd14_data", rsp_rdata[0], 32'd0);
        bus(1'b1, 12'h00C, 32'hFFFF_FFFF, 4'hF);
        check("err.wr0c", 32'(rsp_error[0]), 32'd1);
        bus(1'b1, 12'h010, 32'hFFFF_FFFF, 4'hF);
        check("err.wr10", 32'(rsp_error[0]), 32'd1);
        bus(1'b0, 12'h00C, '0, 4'h0);
        check("err.bootmode_kept", rsp_rdata[0], 32'd0);

        // Byte strobes and back-to-back requests.
        do_reset(2'b00);
        bus(1'b1, 12'h000, 32'hAABB_CCDD, 4'b0010);
        check("strb.boot_addr", boot_addr[0], 32'h0000_CC80);
        bus(1'b1, 12'h000, 32'h1234_5678, 4'b0000);
        check("strb.zero_err", 32'(rsp_error[0]), 32'd0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("b2b.ready", 32'(req_ready[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("b2b.rsp_valid", 32'(rsp_valid[0]), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        req_valid = 1'b0;

        // BootDelay=4: host writes FETCHEN=0 on the auto-set edge.
        do_reset(2'b01);
        tick();                                   // SAMPLE
        repeat (3) tick();
        bus(1'b1, 12'h004, 32'h0, 4'hF);          // accepted on the auto-set edge
        check("race.fetch", 32'(fetch_en[1]), 32'd0);
        bus(1'b0, 12'h010, '0, 4'h0);
        check("race.bootstate", rsp_rdata[1], 32'd3);

        // Reset while a response is pending.
        bus(1'b1, 12'h008, 32'h1234_5678, 4'hF);
        bus(1'b1, 12'h000, 32'h0BAD_0000, 4'hF);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h008;
        if (m_rv[0]) tick();
        tick();                                   // accept, response pending
        req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rstmid.rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rstmid.rdata", rsp_rdata[0], 32'd0);
        check("rstmid.error", 32'(rsp_error[0]), 32'd0);
        check("rstmid.boot_addr", boot_addr[0], 32'h0000_1080);
        check("rstmid.status", core_status[0], 32'd0);
        check("rstmid.fetch", 32'(fetch_en[0]), 32'd0);
        rst_n = 1'b1;

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            bootmode  = 2'($urandom);
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom)
                                                     : 12'($urandom_range(0, 6) * 4 + $urandom_range(0, 3));
            req_wdata = $urandom;
            req_wstrb = 4'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
